// File: rtl/vrf_ctrl_pkg.sv
// Shared types and default parameters for the vector register file sequencer.
package vrf_ctrl_pkg;

  // Default geometry: 8 elements per register, 32 registers, 2-cycle datapath.
  localparam int SIZE_V_DEF  = 8;
  localparam int REG_NUM_DEF = 5;
  localparam int LAT_DEF     = 2;
  localparam int OP_W_DEF    = 4;

  // Sequencer control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/vrf_wr_delay.sv
// Fixed-depth delay line carrying write requests from read time to write time.
// Every stage's valid bit and key field are visible so the sequencer can detect
// reads of a register that still has writes in flight.
module vrf_wr_delay #(
  parameter int DEPTH = 3,
  parameter int W     = 6,
  parameter int KEY_W = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [W-1:0]           data_i,
  output logic                   valid_o,
  output logic [W-1:0]           data_o,
  output logic [DEPTH-1:0]       stage_valid_o,
  output logic [DEPTH*KEY_W-1:0] stage_key_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [W-1:0]     data_q [DEPTH];
  logic [W-1:0]     data_d [DEPTH];

  // Shift every entry one stage further; stage 0 takes the new request.
  always_comb begin
    valid_d[0] = valid_i;
    data_d[0]  = data_i;
    for (int s = 1; s < DEPTH; s++) begin
      valid_d[s] = valid_q[s-1];
      data_d[s]  = data_q[s-1];
    end
  end

  // Pipeline registers; reset empties the line and clears payloads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int s = 0; s < DEPTH; s++) data_q[s] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Expose the key field (top bits of the payload) of every stage.
  always_comb begin
    stage_key_o = '0;
    for (int s = 0; s < DEPTH; s++) begin
      stage_key_o[s*KEY_W +: KEY_W] = data_q[s][W-1 -: KEY_W];
    end
  end

  assign stage_valid_o = valid_q;
  assign valid_o       = valid_q[DEPTH-1];
  assign data_o        = data_q[DEPTH-1];

endmodule

// File: rtl/vrf_sequencer.sv
// Vector instruction sequencer: reads SIZE_V element pairs from the register
// file, then writes each result LAT+1 cycles later. A new instruction may
// start reading while the previous one is still writing, unless it reads a
// register that still has writes pending.
module vrf_sequencer
  import vrf_ctrl_pkg::*;
#(
  parameter int SIZE_V  = SIZE_V_DEF,
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int LAT     = LAT_DEF,
  parameter int OP_W    = OP_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [REG_NUM-1:0]   vs1_i,
  input  logic [REG_NUM-1:0]   vs2_i,
  input  logic [REG_NUM-1:0]   vd_i,
  input  logic [OP_W-1:0]      op_i,
  output logic [2*REG_NUM-1:0] rd_addr_o,
  output logic [1:0]           rd_valid_o,
  output logic [OP_W-1:0]      op_o,
  output logic [REG_NUM-1:0]   wr_addr_o,
  output logic                 wr_valid_o,
  output logic                 done_o,
  output logic                 busy_o
);

  localparam int DEPTH = LAT + 1;
  localparam int CNT_W = (SIZE_V > 1) ? $clog2(SIZE_V) : 1;
  localparam int PAY_W = REG_NUM + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE_V - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REG_NUM-1:0] vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
  logic [OP_W-1:0]    op_q, op_d;

  logic                     issue, elem_last, handshake, hazard, pipe_busy;
  logic                     pipe_out_valid;
  logic [PAY_W-1:0]         pipe_in, pipe_out;
  logic [DEPTH-1:0]         stage_valid;
  logic [DEPTH*REG_NUM-1:0] stage_vd;

  assign issue     = (state_q == ST_ISSUE);
  assign elem_last = issue && (cnt_q == CNT_LAST);
  assign pipe_in   = issue ? {vd_q, elem_last} : '0;

  // Payload is {vd, last}; the key seen by the hazard compare is vd.
  vrf_wr_delay #(
    .DEPTH(DEPTH),
    .W    (PAY_W),
    .KEY_W(REG_NUM)
  ) u_wr_delay (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (issue),
    .data_i       (pipe_in),
    .valid_o      (pipe_out_valid),
    .data_o       (pipe_out),
    .stage_valid_o(stage_valid),
    .stage_key_o  (stage_vd)
  );

  // RAW hold-off: block a new instruction that reads any register still in flight.
  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      if (stage_valid[s] && ((stage_vd[s*REG_NUM +: REG_NUM] == vs1_i) ||
                             (stage_vd[s*REG_NUM +: REG_NUM] == vs2_i))) begin
        hazard = 1'b1;
      end
    end
  end

  assign pipe_busy     = |stage_valid;
  assign instr_ready_o = ((state_q == ST_IDLE) || (state_q == ST_DRAIN)) && !hazard;
  assign handshake     = instr_valid_i && instr_ready_o;

  assign rd_valid_o = {issue, issue};
  assign rd_addr_o  = {vs2_q, vs1_q};
  assign op_o       = op_q;
  assign wr_valid_o = pipe_out_valid;
  assign wr_addr_o  = pipe_out[PAY_W-1:1];
  assign done_o     = pipe_out_valid && pipe_out[0];
  assign busy_o     = (state_q != ST_IDLE) || pipe_busy;

  // Next state, element counter and instruction latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vs1_d   = vs1_q;
    vs2_d   = vs2_q;
    vd_d    = vd_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d = ST_ISSUE;
          cnt_d   = '0;
          vs1_d   = vs1_i;
          vs2_d   = vs2_i;
          vd_d    = vd_i;
          op_d    = op_i;
        end
      end
      ST_ISSUE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (handshake) begin
          state_d = ST_ISSUE;
          cnt_d   = '0;
          vs1_d   = vs1_i;
          vs2_d   = vs2_i;
          vd_d    = vd_i;
          op_d    = op_i;
        end else if (!pipe_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-instruction registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      vd_q    <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      vd_q    <= vd_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_vrf_sequencer.sv
// Scoreboard bench for vrf_sequencer: the driver predicts every read beat and
// write beat of each accepted instruction from its acceptance cycle; a monitor
// pops and compares them as the DUT presents strobes.
module tb_vrf_sequencer;

  localparam int SIZE_V  = 8;
  localparam int REG_NUM = 5;
  localparam int LAT     = 2;
  localparam int OP_W    = 4;

  logic clk_i = 1'b0;
  logic rst_i, instr_valid_i, instr_ready_o;
  logic [REG_NUM-1:0]   vs1_i, vs2_i, vd_i, wr_addr_o;
  logic [OP_W-1:0]      op_i, op_o;
  logic [2*REG_NUM-1:0] rd_addr_o;
  logic [1:0]           rd_valid_o;
  logic wr_valid_o, done_o, busy_o;

  vrf_sequencer #(.SIZE_V(SIZE_V), .REG_NUM(REG_NUM), .LAT(LAT), .OP_W(OP_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .vs1_i(vs1_i), .vs2_i(vs2_i), .vd_i(vd_i),
    .op_i(op_i), .rd_addr_o(rd_addr_o), .rd_valid_o(rd_valid_o), .op_o(op_o),
    .wr_addr_o(wr_addr_o), .wr_valid_o(wr_valid_o), .done_o(done_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { int cyc; logic [2*REG_NUM-1:0] addr; logic [OP_W-1:0] op; } rd_exp_t;
  typedef struct { int cyc; logic [REG_NUM-1:0] vd; logic last; } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  rd_exp_t mon_r;
  wr_exp_t mon_w;

  // Reference model: per-register cycle of the last pending write, end of the
  // current read burst and last cycle the block counts as busy.
  int last_w[32];
  int issue_end  = -1;
  int busy_until = -1;

  int n_checks = 0, n_pass = 0;
  int n_rd = 0, n_wr = 0, n_done = 0;
  bit checking = 1'b0;
  int c_a, c_b, c_x;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  function automatic void model_flush();
    rd_q.delete();
    wr_q.delete();
    issue_end  = -1;
    busy_until = -1;
    for (int r = 0; r < 32; r++) last_w[r] = -1;
  endfunction

  // An instruction accepted in cycle c reads in c+1..c+SIZE_V and writes
  // each element LAT+1 cycles after reading it; last element carries done.
  function automatic void model_accept(input int c, input logic [REG_NUM-1:0] s1, s2, d,
                                       input logic [OP_W-1:0] o);
    for (int e = 0; e < SIZE_V; e++) begin
      rd_q.push_back('{cyc: c + 1 + e, addr: {s2, s1}, op: o});
      wr_q.push_back('{cyc: c + 2 + LAT + e, vd: d, last: (e == SIZE_V - 1)});
    end
    issue_end  = c + SIZE_V;
    last_w[d]  = c + SIZE_V + LAT + 1;
    busy_until = c + SIZE_V + LAT + 2;
  endfunction

  // Offer one instruction until accepted or max_wait cycles elapse; checks
  // instr_ready_o against the model in every offered cycle.
  task automatic applyStimulus(input logic [REG_NUM-1:0] s1, s2, d, input logic [OP_W-1:0] o,
                               input int max_wait, output int acc);
    bit exp_ready;
    acc = -1;
    vs1_i = s1; vs2_i = s2; vd_i = d; op_i = o;
    instr_valid_i = 1'b1;
    for (int k = 0; k < max_wait && acc < 0; k++) begin
      @(negedge clk_i); #1;
      exp_ready = (cyc > issue_end) && (last_w[s1] < cyc) && (last_w[s2] < cyc);
      checkOutput("instr_ready", 64'(instr_ready_o), 64'(exp_ready));
      if (instr_ready_o) begin
        acc = cyc;
        model_accept(cyc, s1, s2, d, o);
      end
      @(posedge clk_i); #1;
    end
    instr_valid_i = 1'b0;
    if (acc < 0) checkOutput("accept_timeout", 64'd1, 64'd0);
  endtask

  // Hold reset for the current cycle; the model forgets everything at the edge.
  task automatic reset_dut();
    instr_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_flush();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk_i); #1; end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && !(cyc > busy_until && rd_q.size() == 0 && wr_q.size() == 0); k++) begin
      @(posedge clk_i); #1;
    end
    checkOutput("idle_busy", 64'(busy_o), 64'd0);
    checkOutput("idle_queues", 64'(rd_q.size() + wr_q.size()), 64'd0);
  endtask

  // Monitor: compare every read and write beat against the scoreboard.
  always @(negedge clk_i) begin
    if (checking) begin
      if (rd_valid_o != 2'b00) begin
        n_rd++;
        if (rd_q.size() == 0) checkOutput("rd_unexpected", 64'(rd_valid_o), 64'd0);
        else begin
          mon_r = rd_q.pop_front();
          checkOutput("rd_beat", 64'({cyc, rd_valid_o, rd_addr_o, op_o}),
                      64'({mon_r.cyc, 2'b11, mon_r.addr, mon_r.op}));
        end
      end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
        mon_r = rd_q.pop_front();
        checkOutput("rd_missing", 64'(rd_valid_o), 64'd3);
      end
      if (wr_valid_o) begin
        n_wr++;
        if (wr_q.size() == 0) checkOutput("wr_unexpected", 64'(wr_valid_o), 64'd0);
        else begin
          mon_w = wr_q.pop_front();
          checkOutput("wr_beat", 64'({cyc, wr_addr_o, done_o}), 64'({mon_w.cyc, mon_w.vd, mon_w.last}));
        end
      end else begin
        checkOutput("done_no_write", 64'(done_o), 64'd0);
        if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
          mon_w = wr_q.pop_front();
          checkOutput("wr_missing", 64'(wr_valid_o), 64'd1);
        end
      end
      if (done_o) n_done++;
      checkOutput("busy", 64'(busy_o), 64'(cyc <= busy_until));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_i = 1'b1; instr_valid_i = 1'b0;
    vs1_i = '0; vs2_i = '0; vd_i = '0; op_i = '0;
    model_flush();
    repeat (2) @(posedge clk_i);
    #1;
    reset_dut();
    @(negedge clk_i); #1;
    checkOutput("reset_state", 64'({rd_valid_o, rd_addr_o, op_o, wr_valid_o, wr_addr_o,
                                    done_o, busy_o, instr_ready_o}), 64'd1);
    checking = 1'b1;
    @(posedge clk_i); #1;

    $display("[TB] independent follow-on instruction");
    applyStimulus(5'd1, 5'd2, 5'd3, 4'd5, 40, c_a);
    wait_until(c_a + 5);
    applyStimulus(5'd4, 5'd5, 5'd6, 4'd7, 40, c_b);
    checkOutput("indep_accept_cycle", 64'(c_b - c_a), 64'd9);
    wait_idle();

    $display("[TB] RAW-dependent follow-on instruction");
    applyStimulus(5'd1, 5'd2, 5'd3, 4'd5, 40, c_a);
    wait_until(c_a + 5);
    applyStimulus(5'd3, 5'd5, 5'd6, 4'd9, 40, c_b);
    checkOutput("raw_accept_cycle", 64'(c_b - c_a), 64'd12);
    wait_idle();

    $display("[TB] randomized instruction stream");
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
      applyStimulus(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 4'($urandom), 40, c_x);
    end
    wait_idle();

    $display("[TB] reset in the middle of an instruction");
    n_rd = 0; n_wr = 0; n_done = 0;
    applyStimulus(5'd1, 5'd2, 5'd3, 4'd5, 40, c_a);
    wait_until(c_a + 6);
    reset_dut();
    fork
      begin
        @(negedge clk_i); #1;
        checkOutput("post_reset_outputs", 64'({rd_valid_o, rd_addr_o, op_o, wr_valid_o,
                                               wr_addr_o, done_o, busy_o}), 64'd0);
      end
      applyStimulus(5'd9, 5'd10, 5'd11, 4'd2, 40, c_b);
    join
    checkOutput("reset_accept_cycle", 64'(c_b - c_a), 64'd7);
    wait_idle();
    checkOutput("reset_reads", 64'(n_rd), 64'd14);
    checkOutput("reset_writes", 64'(n_wr), 64'd11);
    checkOutput("reset_dones", 64'(n_done), 64'd1);

    $display("[TB] eight back-to-back independent instructions");
    n_rd = 0; n_wr = 0; n_done = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(5'(i), 5'(i + 8), 5'(i + 16), 4'(i), 40, c_x);
    end
    wait_idle();
    checkOutput("b2b_reads", 64'(n_rd), 64'd64);
    checkOutput("b2b_writes", 64'(n_wr), 64'd64);
    checkOutput("b2b_dones", 64'(n_done), 64'd8);

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
